reg_ram_arbiter: RTL and testbench
==================================

// Module: reg_ram_arbiter
// PURPOSE
//  Shares the 4-byte register RAM (reg_ram_4B) between two requesters: port 0 = CPU control unit, port 1 = debug/scan.
//  Each port uses a valid/ready command handshake and gets a one-cycle done pulse; the block alone drives the RAM's address, data, we and en.
//  Two-way round-robin arbitration; one transaction in flight; fixed 3-cycle cadence per transaction.
// PARAMETERS
//  ADDR_W  2  RAM address width (4 entries)
//  DATA_W  8  RAM data width
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst           in   1       asynchronous, active-high reset
//  req0_valid    in   1       port 0 command valid; held until req0_ready
//  req0_we       in   1       port 0: 1=write, 0=read
//  req0_addr     in   ADDR_W  port 0 address
//  req0_wdata    in   DATA_W  port 0 write data
//  req0_ready    out  1       port 0 command accepted this cycle
//  req0_done     out  1       port 0 transaction complete (1-cycle pulse)
//  req0_rdata    out  DATA_W  port 0 read data, valid with done on a read, held until next port-0 read completes
//  req1_*        --   --      identical set for port 1
//  ram_addr      out  ADDR_W  to RAM address
//  ram_data_in   out  DATA_W  to RAM data_in
//  ram_we        out  1       to RAM we_in
//  ram_en        out  1       to RAM en_in
//  ram_data_out  in   DATA_W  from RAM data_out (combinational; Z when en=0)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last_grant=1, ram_en=0, ram_we=0, ram_addr=0, ram_data_in=0,
//   both ready=0, both done=0, both rdata=0. In-flight transaction aborted, no done issued;
//   a write whose ACCESS cycle is cut by reset leaves the target byte undefined.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Unused encoding -> IDLE.
//   IDLE: readyN = (state==IDLE) & grantN, combinational. Accept at edge T when valid&ready:
//     latch we/addr/wdata and the winner id; last_grant<=winner; go to ACCESS.
//   ACCESS (cycle T+1): ram_en=1, ram_we=latched we, ram_addr/ram_data_in=latched values.
//     On a read, ram_data_out is captured into the winner's rdata at the end of T+1.
//   RESP (cycle T+2): ram_en=0, ram_we=0; winner's done=1. Next IDLE at T+3, so next accept earliest at edge T+3.
//  ram_en/ram_we are registered and high only in ACCESS. ram_addr/ram_data_in hold their last value outside ACCESS.
//  Arbitration (IDLE only): one valid -> it wins. Both valid -> port != last_grant wins
//   (after reset port 0 wins the first tie). No valid -> no grant, stay IDLE.
//  valid is a request level: dropping it before ready cancels with no side effects; command fields are sampled only at accept.
//  A new valid arriving during ACCESS/RESP waits and sees ready=0.
//  Read-after-write from either port sees the new value: the write completes in ACCESS before any later accept.
//  Non-winner done/rdata unchanged. done never asserts for both ports in the same cycle.
// STRUCTURE
//  Shared defs (minibyte_defs.vh): REG_RAM_ADDR_W=2, REG_RAM_DATA_W=8, ARB_IDLE/ARB_ACCESS/ARB_RESP 2-bit state codes.
//  Sub-module rr_arb2: 2-way round-robin, inputs valid[1:0], last_grant, enable -> one-hot grant[1:0].
//  Top: FSM, command latch, RAM drive registers, per-port rdata registers.
// TESTING (bench instantiates reg_ram_4B behind this block)
//  1 rst pulse mid-ACCESS of a port-0 write -> all outputs at reset values in the same cycle, no req0_done; next tie goes to port 0.
//  2 port0 write addr=2 data=0xA5 -> ready at T, ram_en=ram_we=1 at T+1 only, req0_done at T+2; then port0 read addr=2 -> req0_rdata=0xA5 with done.
//  3 both valid, reset state -> port 0 at T, port 1 at T+3; both held valid -> alternating 0,1,0,1 grants every 3 cycles.
//  4 port1 write addr=3 0x3C, then port0 read addr=3 -> req0_rdata=0x3C; req1_rdata unchanged from its prior value.
//  5 port0 valid pulsed 1 cycle while the block is in ACCESS for port 1 -> never accepted, no RAM access, no req0_done.
//  6 writes 0x11,0x22,0x33,0x44 to addrs 0-3 via alternating ports, read all back -> exact bytes; ram_en=0 in every IDLE/RESP cycle.

Source files
------------

// File: rtl/reg_ram_arbiter_pkg.sv
// Shared definitions for the register-RAM arbiter slice.
//  - RAM geometry of the 4-byte register RAM
//  - arbiter FSM state codes (2-bit, legacy-compatible constants)
//  - small helpers used by the top and the round-robin sub-module
package reg_ram_arbiter_pkg;

  localparam int unsigned REG_RAM_ADDR_W = 2;
  localparam int unsigned REG_RAM_DATA_W = 8;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  // Requester ids
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DEBUG = 1'b1;

  // One-hot grant vector for a single requester id.
  function automatic logic [1:0] port_onehot(logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/reg_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//  valid[1:0]  requests from port 0 / port 1
//  last_grant  id of the port that won most recently
//  enable      arbitration allowed this cycle (arbiter idle)
//  grant[1:0]  one-hot grant, all zero when disabled or nothing valid
module reg_ram_arbiter_rr_arb2
  import reg_ram_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = port_onehot(PORT_CPU);
        2'b10:   grant = port_onehot(PORT_DEBUG);
        // Tie: the port that did not win last time goes first.
        2'b11:   grant = port_onehot(~last_grant);
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/reg_ram_arbiter.sv
// Register-RAM arbiter: shares the 4-byte register RAM between the CPU control
// unit (port 0) and the debug/scan port (port 1).
//  clk, rst                      clock, asynchronous active-high reset
//  reqN_valid/we/addr/wdata      command from port N (held until reqN_ready)
//  reqN_ready                    command accepted this cycle (combinational)
//  reqN_done                     one-cycle completion pulse
//  reqN_rdata                    last read data for port N, held between reads
//  ram_addr/ram_data_in/ram_we/ram_en   registered RAM drive
//  ram_data_out                  combinational RAM read data
// One transaction in flight, fixed cadence IDLE -> ACCESS -> RESP -> IDLE.
module reg_ram_arbiter
  import reg_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_RAM_ADDR_W,
  parameter int unsigned DATA_W = REG_RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // Port 0: CPU control unit
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  // Port 1: debug/scan
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q;
  logic              winner_q;
  logic [1:0]        grant;
  logic              arb_enable;
  logic              accept;
  logic              win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              in_access;

  // Reset gates the enable so ready stays low for the whole reset pulse.
  assign arb_enable = (state_q == ARB_IDLE) && !rst;

  reg_ram_arbiter_rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_enable),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign win_id     = grant[1];
  assign in_access  = (state_q == ARB_ACCESS);

  // Winning command fields, sampled only on accept.
  always_comb begin
    win_we    = req0_we;
    win_addr  = req0_addr;
    win_wdata = req0_wdata;
    if (win_id) begin
      win_we    = req1_we;
      win_addr  = req1_addr;
      win_wdata = req1_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   state_d = accept ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS: state_d = ARB_RESP;
      ARB_RESP:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
    end else begin
      state_q <= state_d;
      // The RAM drive registers double as the command latch: loaded on
      // accept, so en/we are high exactly for the ACCESS cycle and the
      // address/data hold their last value afterwards.
      ram_en  <= accept;
      ram_we  <= accept & win_we;
      if (accept) begin
        last_grant_q <= win_id;
        winner_q     <= win_id;
        ram_addr     <= win_addr;
        ram_data_in  <= win_wdata;
      end
    end
  end

  // Done pulses in RESP; read data captured at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_done <= in_access & ~winner_q;
      req1_done <= in_access & winner_q;
      if (in_access && !ram_we) begin
        if (winner_q) begin
          req1_rdata <= ram_data_out;
        end else begin
          req0_rdata <= ram_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_ram_arbiter.sv
module tb_reg_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req0_ready, req0_done;
  logic [1:0] req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_we, req1_ready, req1_done;
  logic [1:0] req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  logic [1:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_we, ram_en;

  always #5 clk = ~clk;

  reg_ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .req0_done    (req0_done),
    .req0_rdata   (req0_rdata),
    .req1_valid   (req1_valid),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .req1_done    (req1_done),
    .req1_rdata   (req1_rdata),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_en       (ram_en),
    .ram_data_out (ram_data_out)
  );

  // 4-byte register RAM behind the arbiter; floating bus read as 0.
  logic [7:0] ram_mem [4] = '{default: 8'h00};
  always @(posedge clk) if (ram_en && ram_we) ram_mem[ram_addr] <= ram_data_in;
  assign ram_data_out = ram_en ? ram_mem[ram_addr] : 8'h00;

  int errors = 0;
  int checks = 0;

  // Reference model: transaction schedule kept as cycle numbers.
  int         cyc = 0;
  int         free_at, acc_cyc, resp_cyc;
  bit         lg;
  bit         m_w, m_we;
  logic [1:0] m_addr;
  logic [7:0] m_wd;
  logic [7:0] mem [4];
  bit         mem_ok [4];
  logic [7:0] rd [2];
  bit         rd_ok [2];
  logic [1:0] e_addr;
  logic [7:0] e_din;
  bit         g0, g1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    if (cyc == acc_cyc && m_we) mem_ok[m_addr] = 1'b0;
    free_at  = 0;
    acc_cyc  = -1;
    resp_cyc = -1;
    lg       = 1'b1;
    rd[0] = 8'h00; rd[1] = 8'h00;
    rd_ok[0] = 1'b1; rd_ok[1] = 1'b1;
    e_addr = 2'd0;
    e_din  = 8'h00;
  endtask

  // Sample outputs 1 time unit after inputs settle and compare with the model.
  task automatic settle();
    bit idle;
    #1;
    idle = (cyc >= free_at) && !rst;
    g0 = 1'b0; g1 = 1'b0;
    if (idle) begin
      if (req0_valid && req1_valid) begin
        g0 = lg; g1 = !lg;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("ram_en", ram_en, cyc == acc_cyc);
    chk("ram_we", ram_we, (cyc == acc_cyc) && m_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_data_in", ram_data_in, e_din);
    chk("done0", req0_done, (cyc == resp_cyc) && !m_w);
    chk("done1", req1_done, (cyc == resp_cyc) && m_w);
    if (rd_ok[0]) chk("rdata0", req0_rdata, rd[0]);
    if (rd_ok[1]) chk("rdata1", req1_rdata, rd[1]);
  endtask

  // Apply the effects of the coming clock edge to the model, then move on.
  task automatic advance();
    if (rst) begin
      model_reset();
    end else begin
      if (cyc == acc_cyc) begin
        if (m_we) begin
          mem[m_addr] = m_wd; mem_ok[m_addr] = 1'b1;
        end else begin
          rd[m_w] = mem[m_addr]; rd_ok[m_w] = mem_ok[m_addr];
        end
      end
      if (g0 || g1) begin
        m_w    = g1;
        lg     = g1;
        m_we   = g1 ? req1_we : req0_we;
        m_addr = g1 ? req1_addr : req0_addr;
        m_wd   = g1 ? req1_wdata : req0_wdata;
        acc_cyc  = cyc + 1;
        resp_cyc = cyc + 2;
        free_at  = cyc + 3;
        e_addr = m_addr;
        e_din  = m_wd;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  task automatic drive(input bit port, input bit v, input bit we, input logic [1:0] a,
                       input logic [7:0] d);
    if (port) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic run_cmd(input vec_t r);
    bit got = 1'b0;
    int lat = 0;
    drive(r.port, 1'b1, r.we, r.addr, r.wdata);
    for (int i = 0; i < 8; i++) begin
      settle();
      got = r.port ? req1_ready : req0_ready;
      lat = i;
      advance();
      if (got) break;
    end
    drive(r.port, 1'b0, 1'b0, 2'd0, 8'h00);
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    chk("tbl_latency", lat, 0);
    settle();
    chk("tbl_en", ram_en, 1'b1);
    chk("tbl_we", ram_we, r.we);
    chk("tbl_addr", ram_addr, r.addr);
    advance();
    settle();
    chk("tbl_done", r.port ? req1_done : req0_done, 1'b1);
    chk("tbl_en_resp", ram_en, 1'b0);
    if (!r.we) chk("tbl_rdata", r.port ? req1_rdata : req0_rdata, r.exp_rdata);
    advance();
  endtask

  initial begin
    int en_cnt, d0_cnt;
    tbl[0]  = '{0, 1, 2'd2, 8'hA5, 8'h00};
    tbl[1]  = '{0, 0, 2'd2, 8'h00, 8'hA5};
    tbl[2]  = '{1, 1, 2'd3, 8'h3C, 8'h00};
    tbl[3]  = '{0, 0, 2'd3, 8'h00, 8'h3C};
    tbl[4]  = '{0, 1, 2'd0, 8'h11, 8'h00};
    tbl[5]  = '{1, 1, 2'd1, 8'h22, 8'h00};
    tbl[6]  = '{0, 1, 2'd2, 8'h33, 8'h00};
    tbl[7]  = '{1, 1, 2'd3, 8'h44, 8'h00};
    tbl[8]  = '{1, 0, 2'd0, 8'h00, 8'h11};
    tbl[9]  = '{0, 0, 2'd1, 8'h00, 8'h22};
    tbl[10] = '{1, 0, 2'd2, 8'h00, 8'h33};
    tbl[11] = '{0, 0, 2'd3, 8'h00, 8'h44};
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'h00; mem_ok[i] = 1'b1;
    end
    m_w = 1'b0; m_we = 1'b0; m_addr = 2'd0; m_wd = 8'h00;
    acc_cyc = -1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    settle();
    advance();
    rst = 1'b0;

    // Reset cut into the ACCESS cycle of a port-0 write.
    drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h77);
    settle();
    advance();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    settle();
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 2'd0);
    advance();
    rst = 1'b0;
    settle();
    chk("rst_no_done0", req0_done, 1'b0);
    advance();

    // Both held valid from reset state: grants alternate 0,1,0,1.
    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      settle();
      if (k % 3 == 0) chk("rr_grant", {req1_ready, req0_ready}, ((k / 3) % 2) ? 2'b10 : 2'b01);
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    // Write/read-back and cross-port read-after-write.
    for (int i = 0; i < 4; i++) run_cmd(tbl[i]);
    chk("rdata1_kept", req1_rdata, 8'h00);

    // Port-0 one-cycle pulse while port 1 is in ACCESS.
    drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    settle();
    advance();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF);
    en_cnt = 0; d0_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      en_cnt += int'(ram_en);
      d0_cnt += int'(req0_done);
      advance();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    end
    chk("pulse_en_cycles", en_cnt, 1);
    chk("pulse_no_done0", d0_cnt, 0);
    chk("pulse_rdata1", req1_rdata, 8'hA5);

    // Fill all four bytes via alternating ports and read back.
    for (int i = 4; i < 12; i++) run_cmd(tbl[i]);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'b0, $urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), 8'($urandom));
      drive(1'b1, $urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), 8'($urandom));
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
